uart_hex_sender: RTL and testbench

Transmit end of the monitor's read-back path. Accepts a 64-bit read-back word (or a 32-bit PC value) on a start pulse from the monitor logic. Formats it as uppercase hex ASCII with separator and CR/LF, then serializes it 8N1 on the UART TX line. Pulses flushing_wq when the last stop bit completes, so the monitor dump sequencer can fetch the next word.

---
 rtl/uart_hex_sender.sv | 157 +++++++++++++++
 tb/tb_uart_hex_sender.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_sender.sv
// Serial read-back transmitter: formats a 64-bit word (or the low 32 bits) as hex ASCII
// with separator and CR/LF, then sends it 8N1 on uart_tx.
module uart_hex_sender #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        pc_print_sel,
  output logic        flushing_wq,
  output logic        snd_busy,
  output logic        snd_overrun,
  output logic        uart_tx
);

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned BIT_W      = 3;
  localparam int unsigned LONG_LAST  = 18;
  localparam int unsigned SHORT_LAST = 9;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t             state;
  logic [63:0]        shadow;
  logic               mode;
  logic [IDX_W-1:0]   char_idx;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   baud_cnt;

  logic [31:0]        hex_word;
  logic [2:0]         hex_pos;
  logic [3:0]         nibble;
  logic [7:0]         cur_char;
  logic [IDX_W-1:0]   last_char;
  logic               baud_tick;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

  // Character currently on the wire, chosen from the char index and frame mode.
  always_comb begin
    hex_word = shadow[31:0];
    hex_pos  = 3'(char_idx);
    if (!mode && char_idx >= 5'd9) begin
      hex_word = shadow[63:32];
      hex_pos  = 3'(char_idx - 5'd9);
    end
    nibble   = 4'(hex_word >> {3'd7 - hex_pos, 2'b00});
    cur_char = hex_ascii(nibble);
    if (mode) begin
      if (char_idx == 5'd8) begin
        cur_char = 8'h0D;
      end else if (char_idx >= 5'd9) begin
        cur_char = 8'h0A;
      end
    end else begin
      if (char_idx == 5'd8) begin
        cur_char = 8'h20;
      end else if (char_idx == 5'd17) begin
        cur_char = 8'h0D;
      end else if (char_idx >= 5'd18) begin
        cur_char = 8'h0A;
      end
    end
  end

  assign last_char = mode ? IDX_W'(SHORT_LAST) : IDX_W'(LONG_LAST);
  assign baud_tick = (baud_cnt == BAUD_LAST);

  // Frame sequencer; every output is registered so uart_tx is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      mode        <= 1'b0;
      char_idx    <= '0;
      bit_cnt     <= '0;
      baud_cnt    <= '0;
      uart_tx     <= 1'b1;
      snd_busy    <= 1'b0;
      flushing_wq <= 1'b0;
      snd_overrun <= 1'b0;
    end else begin
      flushing_wq <= 1'b0;
      snd_overrun <= rdata_snd_start && snd_busy;
      unique case (state)
        IDLE, DONE: begin
          if (rdata_snd_start) begin
            shadow   <= rdata_snd;
            mode     <= pc_print_sel;
            char_idx <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
            snd_busy <= 1'b1;
            state    <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= cur_char[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              uart_tx <= cur_char[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (char_idx == last_char) begin
              snd_busy    <= 1'b0;
              flushing_wq <= 1'b1;
              state       <= DONE;
            end else begin
              char_idx <= char_idx + 5'd1;
              uart_tx  <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender: decodes the serial line and checks frame
// contents, pulse timing, overrun, mid-frame reset and back-to-back starts.
module tb_uart_hex_sender;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdata_snd_start = 1'b0;
  logic [63:0] rdata_snd = '0;
  logic        pc_print_sel = 1'b0;
  logic        flushing_wq;
  logic        snd_busy;
  logic        snd_overrun;
  logic        uart_tx;

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    flush_q[$];
  int    ovr_q[$];
  string rx_hex = "";

  bit         mon_act = 1'b0;
  int         mon_rel = 0;
  logic [7:0] mon_byte = '0;

  uart_hex_sender #(.CLK_DIV(32'(CD))) dut (
    .clk             (clk),
    .rst             (rst),
    .rdata_snd_start (rdata_snd_start),
    .rdata_snd       (rdata_snd),
    .pc_print_sel    (pc_print_sel),
    .flushing_wq     (flushing_wq),
    .snd_busy        (snd_busy),
    .snd_overrun     (snd_overrun),
    .uart_tx         (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples mid-bit on the falling edge, records pulses with their cycle.
  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else begin
      if (flushing_wq === 1'b1) flush_q.push_back(cyc);
      if (snd_overrun === 1'b1) ovr_q.push_back(cyc);
      if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          mon_act = 1'b1;
          mon_rel = 0;
        end
      end else begin
        mon_rel++;
        if (mon_rel >= CD + CD / 2 && mon_rel < 9 * CD && ((mon_rel - CD / 2) % CD) == 0)
          mon_byte[(mon_rel - CD - CD / 2) / CD] = uart_tx;
        if (mon_rel == 9 * CD + CD / 2) begin
          rx_hex  = {rx_hex, $sformatf("%02h", mon_byte)};
          mon_act = 1'b0;
        end
      end
    end
  end

  function automatic string to_hex(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h", s[i])};
    return r;
  endfunction

  task automatic clear_mon();
    flush_q.delete();
    ovr_q.delete();
    rx_hex = "";
  endtask

  // Called at 1 ns after a rising edge; t is the cycle the start is presented in.
  task automatic start_frame(input logic [63:0] d, input logic sel, output int t);
    rdata_snd       = d;
    pc_print_sel    = sel;
    rdata_snd_start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    rdata_snd_start = 1'b0;
    rdata_snd       = {$urandom, $urandom};
    pc_print_sel    = ~sel;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rdata_snd       = {$urandom, $urandom};
      rdata_snd_start = 1'($urandom_range(0, 1));
      pc_print_sel    = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", uart_tx); end
      tests++; if (snd_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", snd_busy); end
      tests++; if (flushing_wq !== 1'b0) begin fails++; $display("FAIL reset_flush got %b want 0", flushing_wq); end
      tests++; if (snd_overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr got %b want 0", snd_overrun); end
      @(posedge clk);
      #1;
    end
    rdata_snd_start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic test_long();
    int t;
    logic [9:0] wav;
    string exp;
    wav = {1'b1, 8'h38, 1'b0};
    exp = {to_hex("89ABCDEF 01234567"), "0d0a"};
    clear_mon();
    start_frame(64'h0123_4567_89AB_CDEF, 1'b0, t);
    @(negedge clk);
    tests++; if (snd_busy !== 1'b1) begin fails++; $display("FAIL long_busy got %b want 1", snd_busy); end
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < CD; j++) begin
        if (b != 0 || j != 0) @(negedge clk);
        tests++;
        if (uart_tx !== wav[b]) begin
          fails++;
          $display("FAIL long_wave bit %0d cyc %0d got %b want %b", b, j, uart_tx, wav[b]);
        end
      end
    end
    wait_until(t + 770);
    tests++;
    if (flush_q.size() != 1 || flush_q[0] != t + 761) begin
      fails++;
      $display("FAIL long_flush count %0d first %0d want 1 at %0d", flush_q.size(),
               (flush_q.size() > 0) ? flush_q[0] : -1, t + 761);
    end
    tests++; if (rx_hex != exp) begin fails++; $display("FAIL long_decode got %s want %s", rx_hex, exp); end
    tests++; if (ovr_q.size() != 0) begin fails++; $display("FAIL long_ovr got %0d pulses want 0", ovr_q.size()); end
    tests++; if (snd_busy !== 1'b0) begin fails++; $display("FAIL long_idle_busy got %b want 0", snd_busy); end
  endtask

  task automatic test_short();
    int t;
    string exp;
    exp = {to_hex("00001F40"), "0d0a"};
    clear_mon();
    start_frame(64'hDEAD_BEEF_0000_1F40, 1'b1, t);
    wait_until(t + 410);
    tests++;
    if (flush_q.size() != 1 || flush_q[0] != t + 401) begin
      fails++;
      $display("FAIL short_flush count %0d first %0d want 1 at %0d", flush_q.size(),
               (flush_q.size() > 0) ? flush_q[0] : -1, t + 401);
    end
    tests++; if (rx_hex != exp) begin fails++; $display("FAIL short_decode got %s want %s", rx_hex, exp); end
  endtask

  task automatic test_overrun();
    int t;
    string exp;
    exp = {to_hex("89ABCDEF 01234567"), "0d0a"};
    clear_mon();
    start_frame(64'h0123_4567_89AB_CDEF, 1'b0, t);
    wait_until(t + 50);
    rdata_snd       = 64'hFFFF_0000_5555_AAAA;
    pc_print_sel    = 1'b1;
    rdata_snd_start = 1'b1;
    @(posedge clk);
    #1;
    rdata_snd_start = 1'b0;
    wait_until(t + 770);
    tests++;
    if (ovr_q.size() != 1 || ovr_q[0] != t + 51) begin
      fails++;
      $display("FAIL ovr_pulse count %0d first %0d want 1 at %0d", ovr_q.size(),
               (ovr_q.size() > 0) ? ovr_q[0] : -1, t + 51);
    end
    tests++; if (rx_hex != exp) begin fails++; $display("FAIL ovr_decode got %s want %s", rx_hex, exp); end
    tests++;
    if (flush_q.size() != 1 || flush_q[0] != t + 761) begin
      fails++;
      $display("FAIL ovr_flush count %0d first %0d want 1 at %0d", flush_q.size(),
               (flush_q.size() > 0) ? flush_q[0] : -1, t + 761);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int t2;
    string exp;
    exp = {to_hex("00000000"), "0d0a"};
    clear_mon();
    start_frame(64'h0123_4567_89AB_CDEF, 1'b0, t);
    wait_until(t + 125);
    #2;
    tests++; if (uart_tx !== 1'b0) begin fails++; $display("FAIL rstmid_pre_tx got %b want 0", uart_tx); end
    rst = 1'b1;
    #1;
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx got %b want 1", uart_tx); end
    tests++; if (snd_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", snd_busy); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    wait_until(t + 800);
    tests++; if (flush_q.size() != 0) begin fails++; $display("FAIL rstmid_flush got %0d pulses want 0", flush_q.size()); end
    clear_mon();
    start_frame(64'h0, 1'b1, t2);
    wait_until(t2 + 410);
    tests++; if (rx_hex != exp) begin fails++; $display("FAIL rstmid_decode got %s want %s", rx_hex, exp); end
    tests++;
    if (flush_q.size() != 1 || flush_q[0] != t2 + 401) begin
      fails++;
      $display("FAIL rstmid_after_flush count %0d first %0d want 1 at %0d", flush_q.size(),
               (flush_q.size() > 0) ? flush_q[0] : -1, t2 + 401);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int t3;
    int d[3];
    string exp;
    exp = {to_hex("CAFEF00D"), "0d0a", to_hex("33334444 11112222"), "0d0a",
           to_hex("1234ABCD"), "0d0a"};
    clear_mon();
    start_frame(64'h0000_0000_CAFE_F00D, 1'b1, t1);
    d[0] = t1 + 401;
    wait_until(d[0]);
    start_frame(64'h1111_2222_3333_4444, 1'b0, t2);
    @(negedge clk);
    tests++; if (uart_tx !== 1'b0) begin fails++; $display("FAIL b2b_startbit got %b want 0", uart_tx); end
    tests++; if (snd_busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", snd_busy); end
    d[1] = t2 + 761;
    wait_until(d[1] + 3);
    start_frame(64'hFFFF_FFFF_1234_ABCD, 1'b1, t3);
    d[2] = t3 + 401;
    wait_until(d[2] + 9);
    tests++; if (ovr_q.size() != 0) begin fails++; $display("FAIL b2b_ovr got %0d pulses want 0", ovr_q.size()); end
    tests++;
    if (flush_q.size() != 3) begin
      fails++;
      $display("FAIL b2b_flush_count got %0d want 3", flush_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (flush_q[i] != d[i]) begin
          fails++;
          $display("FAIL b2b_flush_%0d got %0d want %0d", i, flush_q[i], d[i]);
        end
      end
    end
    tests++; if (rx_hex != exp) begin fails++; $display("FAIL b2b_decode got %s want %s", rx_hex, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_long();
    test_short();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
